// File: rtl/optest_pkg.sv
// Shared types and the normaliser terminate condition for optest_norm8.
package optest_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Widest operand the helper below can inspect.
    localparam int NORM_MAX_W = 64;

    // True when the accumulator is normalised. Unsigned: MSB set. Signed: the
    // top two bits differ, or every redundant sign bit has already been removed
    // (only an all-ones operand reaches that point).
    function automatic logic norm_done(input logic [NORM_MAX_W-1:0] acc,
                                       input logic                  sgn,
                                       input int                    count,
                                       input int                    width);
        logic [NORM_MAX_W-1:0] top2;
        top2 = acc >> (width - 2);
        if (sgn == MODE_SIGNED)
            return (top2[1] != top2[0]) || (count == width - 1);
        else
            return top2[1];
    endfunction

endpackage

// File: rtl/optest_norm8.sv
// Sequential one-bit-per-cycle normaliser: recovers the left-shift amount and
// the normalised value of an operand (leading zeros or redundant sign bits).
module optest_norm8
    import optest_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_shamt,
    output logic             out_zero
);

    norm_state_e      state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_shamt_q, out_shamt_d;
    logic             out_zero_q, out_zero_d;
    logic             done_w;

    // Terminate condition on the current accumulator contents.
    always_comb begin
        done_w = norm_done(NORM_MAX_W'(acc_q), sgn_q, 32'(cnt_q), WIDTH);
    end

    // Next-state, datapath and result-capture logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_shamt_d = out_shamt_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = in_data;
                    sgn_d = in_signed;
                    cnt_d = '0;
                    if (in_data == '0) begin
                        // A zero operand never normalises; report it directly.
                        state_d     = DONE;
                        out_data_d  = '0;
                        out_shamt_d = CNT_W'(WIDTH);
                        out_zero_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (done_w) begin
                    state_d     = DONE;
                    out_data_d  = acc_q;
                    out_shamt_d = cnt_q;
                    out_zero_d  = 1'b0;
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and the visible result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_shamt_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_shamt_q <= out_shamt_d;
            out_zero_q  <= out_zero_d;
        end
    end

    // Working shift register and counter; always loaded on accept, so no reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        sgn_q <= sgn_d;
        cnt_q <= cnt_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_shamt = out_shamt_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_optest_norm8.sv
// Scoreboard bench for optest_norm8.
module tb_optest_norm8;
    import optest_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_signed = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_shamt;
    logic       out_zero;

    typedef struct {
        logic [7:0] din;
        logic       sgn;
        logic [7:0] data;
        logic [3:0] shamt;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    optest_norm8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] d, input logic s);
        exp_t e;
        logic [7:0] acc;
        int c;
        e.din = d;
        e.sgn = s;
        if (d == 8'h00) begin
            e.data = 8'h00; e.shamt = 4'd8; e.zero = 1'b1;
        end else begin
            acc = d;
            c = 0;
            while (!norm_done(64'(acc), s, c, 8) && c < 8) begin
                acc = acc << 1;
                c++;
            end
            e.data = acc; e.shamt = 4'(c); e.zero = 1'b0;
        end
        return e;
    endfunction

    // Offer one operand; returns 1 time unit after the accept edge.
    task automatic send(input logic [7:0] d, input logic s);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_data = d; in_signed = s;
        sb.push_back(model(d, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge (inclusive) until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready === 1'b1 && out_valid === 1'b0 && out_data === 8'h00 &&
            out_shamt === 4'd0 && out_zero === 1'b0) pass_cnt++;
        else $display("FAIL reset_state: got rdy=%b vld=%b d=%h sh=%0d z=%b want rdy=1 vld=0 d=00 sh=0 z=0",
                      in_ready, out_valid, out_data, out_shamt, out_zero);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [7:0] d, input logic s,
                                 input logic [7:0] want_d, input logic [3:0] want_sh,
                                 input logic want_z, input int want_lat);
        int lat;
        exp_t e;
        send(d, s);
        wait_valid(lat);
        total_cnt++;
        if (lat === want_lat) pass_cnt++;
        else $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
        total_cnt++;
        if (out_data === want_d && out_shamt === want_sh && out_zero === want_z) pass_cnt++;
        else $display("FAIL %s_result: got d=%h sh=%0d z=%b want d=%h sh=%0d z=%b",
                      name, out_data, out_shamt, out_zero, want_d, want_sh, want_z);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (out_data === e.data && out_shamt === e.shamt && out_zero === e.zero) pass_cnt++;
            else $display("FAIL %s_model: got d=%h sh=%0d want d=%h sh=%0d",
                          name, out_data, out_shamt, e.data, e.shamt);
        end
        if (s && !want_z) begin
            total_cnt++;
            if (($signed(out_data) >>> out_shamt) === $signed(d)) pass_cnt++;
            else $display("FAIL %s_inverse: got %h>>>%0d want %h", name, out_data, out_shamt, d);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] hd;
        logic [3:0] hs;
        logic ok;
        send(8'h05, MODE_UNSIGNED);
        wait_valid(lat);
        hd = out_data; hs = out_shamt;
        ok = (out_valid === 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33; in_signed = 1'b1;
            @(posedge clk);
            #1;
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_data === hd && out_shamt === hs))
                ok = 1'b0;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (ok && hd === 8'hA0 && hs === 4'd5) pass_cnt++;
        else $display("FAIL bp_hold: got vld=%b rdy=%b d=%h sh=%0d want vld=1 rdy=0 d=a0 sh=5",
                      out_valid, in_ready, out_data, out_shamt);
        void'(sb.pop_front());
        release_out();
        total_cnt++;
        if (out_valid === 1'b0 && in_ready === 1'b1) pass_cnt++;
        else $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        repeat (12) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid === 1'b0 && in_ready === 1'b1) pass_cnt++;
        else $display("FAIL bp_ignored_input: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    endtask

    task automatic test_reset_mid();
        send(8'h01, MODE_UNSIGNED);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid === 1'b0 && in_ready === 1'b1) pass_cnt++;
        else $display("FAIL reset_mid: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed("after_reset", 8'h40, MODE_UNSIGNED, 8'h80, 4'd1, 1'b0, 3);
    endtask

    task automatic test_sweep();
        int lat, n;
        exp_t e;
        logic inv_ok;
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                send(8'(v), 1'(s));
                wait_valid(lat);
                e = sb.pop_front();
                total_cnt++;
                if (out_valid === 1'b1 && out_data === e.data && out_shamt === e.shamt &&
                    out_zero === e.zero) pass_cnt++;
                else $display("FAIL sweep s=%0d in=%h: got vld=%b d=%h sh=%0d z=%b want d=%h sh=%0d z=%b",
                              s, e.din, out_valid, out_data, out_shamt, out_zero, e.data, e.shamt, e.zero);
                if (e.zero) inv_ok = (out_data === 8'h00);
                else if (e.sgn) inv_ok = (($signed(out_data) >>> out_shamt) === $signed(e.din));
                else inv_ok = ((out_data >> out_shamt) === e.din);
                total_cnt++;
                if (inv_ok && (!e.sgn || e.zero || out_shamt <= 4'd7)) pass_cnt++;
                else $display("FAIL sweep_inverse s=%0d in=%h: got d=%h sh=%0d", s, e.din, out_data, out_shamt);
                n = 0;
                do begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    n++;
                end while (!out_ready && n < 20);
                #1;
                out_ready = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("unsigned_05", 8'h05, MODE_UNSIGNED, 8'hA0, 4'd5, 1'b0, 7);
        test_directed("signed_f4",   8'hF4, MODE_SIGNED,   8'hA0, 4'd3, 1'b0, 5);
        test_directed("signed_03",   8'h03, MODE_SIGNED,   8'h60, 4'd5, 1'b0, 7);
        test_directed("zero",        8'h00, MODE_UNSIGNED, 8'h00, 4'd8, 1'b1, 1);
        test_directed("signed_ff",   8'hFF, MODE_SIGNED,   8'h80, 4'd7, 1'b0, 9);
        test_directed("unsigned_80", 8'h80, MODE_UNSIGNED, 8'h80, 4'd0, 1'b0, 2);
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
